// File: rtl/pipe_skid_reg.sv
// Two-entry skid register stage: main entry drives q directly, skid entry
// absorbs one payload during a stall so in_ready can come straight from a flop.
//
// state | meaning
// ------+--------------------------------------------------
// EMPTY | no live entry, q = CLEAR_VAL, in_ready = 1
// BUSY  | main live on q, skid empty, in_ready = 1
// FULL  | main and skid both live, in_ready = 0

module pipe_skid_reg #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             xfer_in, xfer_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= CLEAR_VAL;
      skid_q <= CLEAR_VAL;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    unique case (state)
      EMPTY: begin
        if (xfer_in) begin
          main_nxt  = d;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (xfer_in && xfer_out) begin
          main_nxt = d;
        end else if (xfer_in) begin
          skid_nxt  = d;
          state_nxt = FULL;
        end else if (xfer_out) begin
          main_nxt  = CLEAR_VAL;
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (xfer_out) begin
          main_nxt  = skid_q;
          skid_nxt  = CLEAR_VAL;
          state_nxt = BUSY;
        end
      end
      default: begin
        main_nxt  = CLEAR_VAL;
        skid_nxt  = CLEAR_VAL;
        state_nxt = EMPTY;
      end
    endcase
    // Flush wins over any handshake in the same cycle.
    if (clear) begin
      main_nxt  = CLEAR_VAL;
      skid_nxt  = CLEAR_VAL;
      state_nxt = EMPTY;
    end
  end

  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    q         = main_q;
    unique case (state)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed handshake scenarios on a 32-bit stage plus
// randomized traffic on 32-bit/clear-0 and 8-bit/clear-ones stages vs a queue model.

module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear, in_valid, out_ready;
  logic [31:0] d32, q32;
  logic [7:0]  d8, q8;
  logic        ir32, ov32, ir8, ov8;
  logic [1:0]  occ32, occ8;

  int errors = 0;
  int checks = 0;

  pipe_skid_reg #(.WIDTH(32), .CLEAR_VAL(32'h0)) dut32 (
    .clk(clk), .rst(rst), .clear(clear), .d(d32), .in_valid(in_valid),
    .in_ready(ir32), .q(q32), .out_valid(ov32), .out_ready(out_ready), .occ(occ32)
  );

  pipe_skid_reg #(.WIDTH(8), .CLEAR_VAL(8'hFF)) dut8 (
    .clk(clk), .rst(rst), .clear(clear), .d(d8), .in_valid(in_valid),
    .in_ready(ir8), .q(q8), .out_valid(ov8), .out_ready(out_ready), .occ(occ8)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d32 = 32'h0; d8 = 8'h0;
    cyc();
    checks++; if (q32 !== 32'h0) begin errors++; $display("FAIL reset_q32 got=%h exp=%h", q32, 32'h0); end
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_ov32 got=%b exp=0", ov32); end
    checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL reset_ir32 got=%b exp=1", ir32); end
    checks++; if (occ32 !== 2'd0) begin errors++; $display("FAIL reset_occ32 got=%0d exp=0", occ32); end
    checks++; if (q8 !== 8'hFF) begin errors++; $display("FAIL reset_q8 got=%h exp=ff", q8); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_ov8 got=%b exp=0", ov8); end
    rst = 1'b0;
  endtask

  task automatic test_first_xfer();
    in_valid = 1'b1; d32 = 32'h1; out_ready = 1'b1;
    cyc();
    checks++; if (q32 !== 32'h1) begin errors++; $display("FAIL first_q got=%h exp=%h", q32, 32'h1); end
    checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL first_ov got=%b exp=1", ov32); end
    checks++; if (occ32 !== 2'd1) begin errors++; $display("FAIL first_occ got=%0d exp=1", occ32); end
    in_valid = 1'b0;
    cyc();
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL first_drain_ov got=%b exp=0", ov32); end
    checks++; if (q32 !== 32'h0) begin errors++; $display("FAIL first_drain_q got=%h exp=0", q32); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; d32 = 32'(i);
      cyc();
      checks++; if (q32 !== 32'(i)) begin errors++; $display("FAIL stream_q[%0d] got=%h exp=%h", i, q32, 32'(i)); end
      checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL stream_ir[%0d] got=%b exp=1", i, ir32); end
      checks++; if (occ32 !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occ32); end
    end
    in_valid = 1'b0;
    cyc();
    checks++; if (occ32 !== 2'd0) begin errors++; $display("FAIL stream_end_occ got=%0d exp=0", occ32); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; d32 = 32'hA;
    cyc();
    checks++; if (q32 !== 32'hA) begin errors++; $display("FAIL bp_load_q got=%h exp=a", q32); end
    d32 = 32'hB;
    cyc();
    checks++; if (occ32 !== 2'd2) begin errors++; $display("FAIL bp_full_occ got=%0d exp=2", occ32); end
    checks++; if (ir32 !== 1'b0) begin errors++; $display("FAIL bp_full_ir got=%b exp=0", ir32); end
    checks++; if (q32 !== 32'hA) begin errors++; $display("FAIL bp_full_q got=%h exp=a", q32); end
    d32 = 32'hDEAD;
    cyc();
    checks++; if (q32 !== 32'hA || occ32 !== 2'd2) begin errors++; $display("FAIL bp_hold got q=%h occ=%0d exp q=a occ=2", q32, occ32); end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    checks++; if (q32 !== 32'hB) begin errors++; $display("FAIL bp_second_q got=%h exp=b", q32); end
    checks++; if (occ32 !== 2'd1) begin errors++; $display("FAIL bp_second_occ got=%0d exp=1", occ32); end
    cyc();
    checks++; if (ov32 !== 1'b0 || q32 !== 32'h0) begin errors++; $display("FAIL bp_empty got ov=%b q=%h exp ov=0 q=0", ov32, q32); end
  endtask

  task automatic test_clear();
    out_ready = 1'b0; in_valid = 1'b1; d32 = 32'hA;
    cyc();
    d32 = 32'hB;
    cyc();
    checks++; if (occ32 !== 2'd2) begin errors++; $display("FAIL clr_pre_occ got=%0d exp=2", occ32); end
    clear = 1'b1; d32 = 32'hC; out_ready = 1'b1;
    cyc();
    checks++; if (occ32 !== 2'd0) begin errors++; $display("FAIL clr_occ got=%0d exp=0", occ32); end
    checks++; if (q32 !== 32'h0) begin errors++; $display("FAIL clr_q got=%h exp=0", q32); end
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL clr_ov got=%b exp=0", ov32); end
    clear = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (ov32 !== 1'b0 || q32 !== 32'h0) begin errors++; $display("FAIL clr_after[%0d] got ov=%b q=%h exp ov=0 q=0", i, ov32, q32); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; d32 = 32'h5;
    cyc();
    in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
    cyc();
    checks++; if (ov32 !== 1'b0 || q32 !== 32'h0) begin errors++; $display("FAIL rstmid got ov=%b q=%h exp ov=0 q=0", ov32, q32); end
    checks++; if (ir32 !== 1'b1 || occ32 !== 2'd0) begin errors++; $display("FAIL rstmid_ir got ir=%b occ=%0d exp ir=1 occ=0", ir32, occ32); end
    rst = 1'b0;
    cyc();
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL rstmid_dup got ov=%b q=%h exp ov=0", ov32, q32); end
    in_valid = 1'b1; d32 = 32'h7; out_ready = 1'b0;
    cyc();
    checks++; if (q32 !== 32'h7 || occ32 !== 2'd1) begin errors++; $display("FAIL rstmid_accept got q=%h occ=%0d exp q=7 occ=1", q32, occ32); end
    d32 = 32'h8;
    cyc();
    rst = 1'b1; clear = 1'b1; d32 = 32'h9;
    cyc();
    checks++; if (occ32 !== 2'd0 || q32 !== 32'h0 || ir32 !== 1'b1) begin errors++; $display("FAIL rstclr got occ=%0d q=%h ir=%b exp occ=0 q=0 ir=1", occ32, q32, ir32); end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    cyc();
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL rstclr_after got ov=%b exp=0", ov32); end
  endtask

  task automatic test_random();
    logic [31:0] m32[$];
    logic [7:0]  m8[$];
    logic [31:0] eq32;
    logic [7:0]  eq8;
    int          iv_pct, or_pct;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      eq32 = (m32.size() > 0) ? m32[0] : 32'h0;
      eq8  = (m8.size() > 0) ? m8[0] : 8'hFF;
      checks++; if (occ32 !== 2'(m32.size())) begin errors++; $display("FAIL rnd32_occ c=%0d got=%0d exp=%0d", c, occ32, m32.size()); end
      checks++; if (ov32 !== (m32.size() > 0)) begin errors++; $display("FAIL rnd32_ov c=%0d got=%b", c, ov32); end
      checks++; if (ir32 !== (m32.size() < 2)) begin errors++; $display("FAIL rnd32_ir c=%0d got=%b", c, ir32); end
      checks++; if (q32 !== eq32) begin errors++; $display("FAIL rnd32_q c=%0d got=%h exp=%h", c, q32, eq32); end
      checks++; if (occ8 !== 2'(m8.size())) begin errors++; $display("FAIL rnd8_occ c=%0d got=%0d exp=%0d", c, occ8, m8.size()); end
      checks++; if (ov8 !== (m8.size() > 0)) begin errors++; $display("FAIL rnd8_ov c=%0d got=%b", c, ov8); end
      checks++; if (q8 !== eq8) begin errors++; $display("FAIL rnd8_q c=%0d got=%h exp=%h", c, q8, eq8); end
      // vary traffic mix every 2500 cycles to hit stall-heavy and drain-heavy regimes
      iv_pct = (c / 2500 == 1) ? 90 : (c / 2500 == 2) ? 30 : 60;
      or_pct = (c / 2500 == 1) ? 30 : (c / 2500 == 2) ? 90 : 60;
      in_valid  = ($urandom_range(0, 99) < iv_pct);
      out_ready = ($urandom_range(0, 99) < or_pct);
      clear     = ($urandom_range(0, 199) == 0);
      d32 = $urandom;
      d8  = 8'($urandom);
      if (clear) begin
        m32.delete();
        m8.delete();
      end else begin
        if (m32.size() > 0 && out_ready) begin
          void'(m32.pop_front());
          void'(m8.pop_front());
        end else if (in_valid && m32.size() < 2) begin
          m32.push_back(d32);
          m8.push_back(d8);
        end
        if (in_valid && out_ready && m32.size() == 0) begin
          m32.push_back(d32);
          m8.push_back(d8);
        end
      end
    end
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_xfer();
    test_stream();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
